// File: rtl/gearbox_pkg.sv
// Shared widths and helpers for the 128-to-24 bit gearbox.
// Optional flush feature is enabled by defining GEARBOX_128TO24_FLUSH_EN.
package gearbox_pkg;

    localparam int IN_W       = 128;
    localparam int OUT_W      = 24;
    localparam int BUF_W      = 144;
    localparam int CNT_W      = 8;
    localparam int RDY_THRESH = 48;

    typedef logic [BUF_W-1:0] buf_t;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [IN_W-1:0]  in_word_t;
    typedef logic [OUT_W-1:0] out_word_t;

    // Keeps the top n bits of an output word and zeroes the remainder.
    function automatic out_word_t head_mask(input cnt_t n);
        return ~({OUT_W{1'b1}} >> n);
    endfunction

endpackage

// File: rtl/gearbox_ins_shift.sv
// Merges a 128-bit input word into the MSB-aligned buffer directly below
// the residual bits already held there.
module gearbox_ins_shift
    import gearbox_pkg::*;
(
    input  logic [BUF_W-1:0] i_buf,
    input  logic [CNT_W-1:0] i_residual,
    input  logic [IN_W-1:0]  i_datain,
    output logic [BUF_W-1:0] o_merged
);

    logic [BUF_W-1:0] w_keep;
    logic [BUF_W-1:0] w_ins;

    // Residual is at most 16 when a word is accepted, so the word always fits.
    assign w_keep   = ~({BUF_W{1'b1}} >> i_residual);
    assign w_ins    = {i_datain, {(BUF_W-IN_W){1'b0}}} >> i_residual;
    assign o_merged = (i_buf & w_keep) | w_ins;

endmodule

// File: rtl/gearbox_128to24.sv
// 128-bit to 24-bit width converter, MSB first, with ready-based input flow control.
// Define GEARBOX_128TO24_FLUSH_EN to add the flush port (pad and emit partial residue).
module gearbox_128to24
    import gearbox_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             validin,
    input  logic [IN_W-1:0]  datain,
`ifdef GEARBOX_128TO24_FLUSH_EN
    input  logic             flush,
`endif
    output logic             ready,
    output logic             validout,
    output logic [OUT_W-1:0] dataout
);

    buf_t      r_buf;
    cnt_t      r_cnt;

    logic      w_emit;
    logic      w_accept;
    logic      w_flush;
    buf_t      w_buf_shift;
    buf_t      w_buf_merged;
    buf_t      w_buf_next;
    cnt_t      w_residual;
    cnt_t      w_cnt_next;
    logic      w_valid_next;
    out_word_t w_data_next;

    assign w_emit      = (r_cnt >= cnt_t'(OUT_W));
    assign w_accept    = validin && ready;
    assign w_buf_shift = w_emit ? (r_buf << OUT_W) : r_buf;
    assign w_residual  = w_emit ? (r_cnt - cnt_t'(OUT_W)) : r_cnt;

`ifdef GEARBOX_128TO24_FLUSH_EN
    assign w_flush = flush && !w_accept && (r_cnt != '0) && (r_cnt < cnt_t'(OUT_W));
`else
    assign w_flush = 1'b0;
`endif

    gearbox_ins_shift u_ins_shift (
        .i_buf      (w_buf_shift),
        .i_residual (w_residual),
        .i_datain   (datain),
        .o_merged   (w_buf_merged)
    );

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        w_valid_next = w_emit;
        w_data_next  = dataout;
        w_buf_next   = w_buf_shift;
        w_cnt_next   = w_residual;
        if (w_emit) begin
            w_data_next = r_buf[BUF_W-1 -: OUT_W];
        end
        if (w_accept) begin
            w_buf_next = w_buf_merged;
            w_cnt_next = w_residual + cnt_t'(IN_W);
        end else if (w_flush) begin
            w_valid_next = 1'b1;
            w_data_next  = r_buf[BUF_W-1 -: OUT_W] & head_mask(r_cnt);
            w_buf_next   = '0;
            w_cnt_next   = '0;
        end
    end

    // Ready looks at the next count so an accepted word always fits (residual + 128 <= 144).
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rstn) begin
            r_buf    <= '0;
            r_cnt    <= '0;
            ready    <= 1'b0;
            validout <= 1'b0;
            dataout  <= '0;
        end else begin
            r_buf    <= w_buf_next;
            r_cnt    <= w_cnt_next;
            ready    <= (w_cnt_next < cnt_t'(RDY_THRESH));
            validout <= w_valid_next;
            dataout  <= w_data_next;
        end
    end

endmodule

// File: doc/gearbox_128to24.md
GEARBOX_128TO24 -- requirements
Module: gearbox_128to24

Interface
REQ-001 SHALL have port: clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have port: rstn  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: validin  input  1  datain valid; a word is accepted only when validin && ready.
REQ-004 SHALL have port: datain  input  128  input word; bit 127 is transmitted first.
REQ-005 SHALL have port: ready  output  1  registered; high = a word presented this cycle is accepted.
REQ-006 SHALL have port: validout  output  1  registered; high = dataout holds a new 24-bit word this cycle.
REQ-007 SHALL have port: dataout  output  24  registered output word; dataout[23] is the earliest bit.
REQ-008 SHALL have no parameters; widths are fixed at 128 in and 24 out, with no downstream backpressure.

Function
REQ-009 SHALL hold a 144-bit MSB-aligned buffer buf and an 8-bit bit-count cnt in the range 0..144.
REQ-010 SHALL, at each edge, set emit = (cnt >= 24).
- emit: validout <= 1, dataout <= buf[143:120], buf shifts left by 24, residual = cnt - 24.
- else: validout <= 0, dataout holds its value, residual = cnt.
REQ-011 SHALL, on accept, write datain into buf[143-residual -: 128] after the shift, and set cnt <= residual + 128.
REQ-012 SHALL, without accept, set cnt <= residual.
REQ-013 SHALL register ready <= (cnt_next < 48), so that residual + 128 <= 144 always holds.
REQ-014 SHALL ignore validin while ready = 0; no data is captured and no error is raised. Upstream holds the word.
REQ-015 SHALL emit the first word of datain on the edge after acceptance, giving validout high one cycle after the accept cycle.
REQ-016 SHALL emit, under continuous validin, exactly 16 words per 3 inputs with validout unbroken after the first word. Per-input word counts are 5, 5, 6 and residuals are 8, 16, 0.
REQ-017 SHALL retain residual bits (cnt in 8 or 16) indefinitely when validin is idle; they are never emitted partially.
REQ-018 SHALL handle emit and accept in the same edge, with the shift applied before insertion.

Reset
REQ-019 SHALL, while rstn = 0, force buf = 0, cnt = 0, validout = 0, dataout = 24'h0, ready = 0.
REQ-020 SHALL set ready to 1 at the first edge after rstn deasserts.
REQ-021 SHALL discard all buffered bits on reset mid-stream; the next accepted word starts a fresh alignment.

Configuration
REQ-022 SHALL, when macro GEARBOX_128TO24_FLUSH_EN is defined, add port: flush  input  1  pad-and-emit request.
REQ-023 SHALL, with GEARBOX_128TO24_FLUSH_EN defined, on an edge where flush = 1, cnt in 1..23 and no accept occurs:
- validout <= 1, dataout <= {buf[143 -: cnt], zero pad to 24 bits}, cnt <= 0.
- flush is ignored in all other cases.
REQ-024 SHALL, without GEARBOX_128TO24_FLUSH_EN, have no flush port, and residual bits wait for further input.

Structure
REQ-025 SHALL place IN_W=128, OUT_W=24, BUF_W=144, CNT_W=8 and RDY_THRESH=48 in shared package gearbox_pkg.
REQ-026 SHALL implement the variable-offset insertion as one combinational sub-module, gearbox_ins_shift, with inputs buf, residual and datain and output the merged buffer.
REQ-027 SHALL keep cnt/ready control in the top module, with no further sub-modules.

Verification
REQ-028 SHALL cover: reset, then A, B, C back-to-back with validin = 1.
- validout is high for 16 consecutive cycles starting 1 cycle after A is accepted.
- The concatenated dataout equals {A, B, C}.
REQ-029 SHALL cover: single word 128'h0123456789ABCDEF_FEDCBA9876543210.
- Outputs 24'h012345, 24'h6789AB, 24'hCDEFFE, 24'hDCBA98, 24'h765432, then validout = 0.
- Final state is cnt = 8, ready = 1.
REQ-030 SHALL cover: validin held high for 48 cycles.
- ready pattern is 1, 0, 0, 0, 0, 1 ...
- Exactly 9 words accepted, 48 outputs, no validout gaps.
REQ-031 SHALL cover: a distinct word D presented while ready = 0. D is absent from the output stream and the following accepted word follows directly.
REQ-032 SHALL cover: rstn pulsed low after 7 output words.
- Outputs are 0 during reset and ready = 1 one edge after release.
- The next word E outputs E[127:104] first.
REQ-033 SHALL cover, with GEARBOX_128TO24_FLUSH_EN defined: one word A, 5 outputs, then flush = 1. The next output is {A[7:0], 16'h0000} and cnt = 0.
